// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - requester and RAM-side bus bundle for ram_port_arbiter
interface ram_port_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12
);
    logic                     p0_req;
    logic                     p0_we;
    logic [ADDRESS_WIDTH-1:0] p0_addr;
    logic [DATA_WIDTH-1:0]    p0_wdata;
    logic                     p0_gnt;
    logic                     p0_rvalid;
    logic [DATA_WIDTH-1:0]    p0_rdata;
    logic                     p0_werr;

    logic                     p1_req;
    logic                     p1_we;
    logic [ADDRESS_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0]    p1_wdata;
    logic                     p1_gnt;
    logic                     p1_rvalid;
    logic [DATA_WIDTH-1:0]    p1_rdata;
    logic                     p1_werr;

    logic                     ram_wEn;
    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]    ram_dataIn;
    logic [DATA_WIDTH-1:0]    ram_dataOut;
    logic                     busy;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_werr,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_werr,
        input  ram_wEn, ram_addr, ram_dataIn, busy,
        output ram_dataOut
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p0_gnt, p0_rvalid, p0_rdata, p0_werr,
        output p1_gnt, p1_rvalid, p1_rdata, p1_werr,
        output ram_wEn, ram_addr, ram_dataIn, busy,
        input  ram_dataOut
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-port round-robin arbiter for the single-port game RAM
// Optional build macro: RAM_ARB_FIXED_PRI_EN (fixed priority, port 0 wins ties).
module ram_port_arbiter #(
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       ADDRESS_WIDTH = 12,
    parameter logic [ADDRESS_WIDTH-1:0] RSVD_ADDR     = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    ram_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} state_t;

    state_t                   state_q, state_d;
    logic                     wen_q, wen_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    din_q, din_d;
    logic [1:0]               gnt_q, gnt_d;
    logic [1:0]               werr_q, werr_d;
    logic [1:0]               rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]    rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0]    rdata1_q, rdata1_d;
    logic                     busy_q, busy_d;
    // last_winner doubles as the port whose read is in flight
    logic                     last_winner_q, last_winner_d;
    logic                     acc_we_q, acc_we_d;

    logic                     pick;
    logic                     sel_we;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_wdata;
    logic                     blocked;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            wen_q         <= 1'b0;
            addr_q        <= '0;
            din_q         <= '0;
            gnt_q         <= '0;
            werr_q        <= '0;
            rvalid_q      <= '0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            busy_q        <= 1'b0;
            last_winner_q <= 1'b1;
            acc_we_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            wen_q         <= wen_d;
            addr_q        <= addr_d;
            din_q         <= din_d;
            gnt_q         <= gnt_d;
            werr_q        <= werr_d;
            rvalid_q      <= rvalid_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            busy_q        <= busy_d;
            last_winner_q <= last_winner_d;
            acc_we_q      <= acc_we_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wen_d         = 1'b0;
        addr_d        = addr_q;
        din_d         = din_q;
        gnt_d         = '0;
        werr_d        = '0;
        rvalid_d      = '0;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        last_winner_d = last_winner_q;
        acc_we_d      = acc_we_q;
        pick          = 1'b0;
        sel_we        = 1'b0;
        sel_addr      = '0;
        sel_wdata     = '0;
        blocked       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.p0_req || bus.p1_req) begin
`ifdef RAM_ARB_FIXED_PRI_EN
                    pick = !bus.p0_req;
`else
                    pick = (bus.p0_req && bus.p1_req) ? !last_winner_q : bus.p1_req;
`endif
                    sel_we    = pick ? bus.p1_we    : bus.p0_we;
                    sel_addr  = pick ? bus.p1_addr  : bus.p0_addr;
                    sel_wdata = pick ? bus.p1_wdata : bus.p0_wdata;
                    // Status word is reloaded by the RAM; a write there is dropped
                    // and the RAM just performs a discarded read instead.
                    blocked       = sel_we && (sel_addr == RSVD_ADDR);
                    wen_d         = sel_we && !blocked;
                    addr_d        = sel_addr;
                    din_d         = sel_wdata;
                    acc_we_d      = sel_we;
                    last_winner_d = pick;
                    gnt_d[pick]   = 1'b1;
                    werr_d[pick]  = blocked;
                    state_d       = ACCESS;
                end
            end
            ACCESS: begin
                state_d = acc_we_q ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
                if (last_winner_q) begin
                    rdata1_d = bus.ram_dataOut;
                end else begin
                    rdata0_d = bus.ram_dataOut;
                end
                rvalid_d[last_winner_q] = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.p0_gnt     = gnt_q[0];
    assign bus.p1_gnt     = gnt_q[1];
    assign bus.p0_werr    = werr_q[0];
    assign bus.p1_werr    = werr_q[1];
    assign bus.p0_rvalid  = rvalid_q[0];
    assign bus.p1_rvalid  = rvalid_q[1];
    assign bus.p0_rdata   = rdata0_q;
    assign bus.p1_rdata   = rdata1_q;
    assign bus.ram_wEn    = wen_q;
    assign bus.ram_addr   = addr_q;
    assign bus.ram_dataIn = din_q;
    assign bus.busy       = busy_q;
endmodule
